alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit_if.sv | 33 +++
 rtl/alu_exec_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit_if
// Brief    : Operation/result handshake bundle for alu_exec_unit.
// Revision : 1.0
// ============================================================================
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    modport master (
        output in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Handshaked integer ALU with optional iterative shift-add multiply
//            (enabled by defining ALU_EXEC_MUL_EN).
// Revision : 1.0
// ============================================================================
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  wire logic       clk,
    input  wire logic       rst,
    alu_exec_unit_if.slave  bus
);

`ifdef ALU_EXEC_MUL_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd2} state_t;
`endif

    state_t          r_state;
    logic            r_out_valid;
    logic            r_busy;
    logic [XLEN-1:0] r_result;
    logic            r_zero;

    logic [SHW-1:0]  w_shamt;
    logic            w_is_mext;
    logic            w_in_ready;
    logic            w_accept;
    logic [XLEN-1:0] w_ctz;
    logic [XLEN-1:0] w_alu;

`ifdef ALU_EXEC_MUL_EN
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [SHW-1:0]  r_cnt;
    logic            w_is_mul;
    logic [XLEN-1:0] w_acc_next;

    assign w_is_mul   = (bus.alu_op == 2'b10) && w_is_mext && (bus.funct3 == 3'b000);
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
`endif

    assign w_shamt    = bus.op_b[SHW-1:0];
    assign w_is_mext  = (bus.funct7 == 7'b0000001);
    assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // Scan from the MSB down so the lowest set bit wins; all-zero leaves XLEN.
    always_comb begin
        w_ctz = XLEN'(XLEN);
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (bus.op_a[i]) begin
                w_ctz = XLEN'(i);
            end
        end
    end

    always_comb begin
        w_alu = '0;
        case (bus.alu_op)
            2'b00: w_alu = bus.op_a + bus.op_b;
            2'b01: w_alu = bus.op_a - bus.op_b;
            2'b11: w_alu = w_ctz;
            default: begin
                if (!w_is_mext) begin
                    case (bus.funct3)
                        3'b000: w_alu = bus.funct7[5] ? (bus.op_a - bus.op_b)
                                                      : (bus.op_a + bus.op_b);
                        3'b001: w_alu = bus.op_a << w_shamt;
                        3'b010: w_alu = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
                        3'b011: w_alu = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
                        3'b100: w_alu = bus.op_a ^ bus.op_b;
                        3'b101: w_alu = bus.funct7[5] ? XLEN'($signed(bus.op_a) >>> w_shamt)
                                                      : (bus.op_a >> w_shamt);
                        3'b110: w_alu = bus.op_a | bus.op_b;
                        default: w_alu = bus.op_a & bus.op_b;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
`ifdef ALU_EXEC_MUL_EN
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
`ifdef ALU_EXEC_MUL_EN
                        if (w_is_mul) begin
                            r_state     <= ST_MUL;
                            r_busy      <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_acc       <= '0;
                            r_mcand     <= bus.op_a;
                            r_mplier    <= bus.op_b;
                            r_cnt       <= '0;
                        end else
`endif
                        begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_alu;
                            r_zero      <= (w_alu == '0);
                        end
                    end else if ((r_state == ST_DONE) && bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
`ifdef ALU_EXEC_MUL_EN
                // One multiplier bit per cycle; the last step writes the result directly.
                ST_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == SHW'(XLEN - 1)) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_result    <= w_acc_next;
                        r_zero      <= (w_acc_next == '0);
                    end
                end
`endif
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;

endmodule
`default_nettype wire
